// File: rtl/ysyx_24100029_axi_sram_if.sv
// AXI4 subset bus between a master and the on-chip SRAM slave.
// Size is fixed at 4 bytes, so there is no awsize/arsize.
interface ysyx_24100029_axi_sram_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );
endinterface

// File: rtl/ysyx_24100029_axi_sram.sv
// Single-outstanding AXI4 SRAM slave at 0x8000_0000.
// FIXED/INCR bursts, byte strobes, SLVERR on range/burst faults.
module ysyx_24100029_axi_sram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned RD_LAT    = 2
) (
  input logic clock,
  input logic reset,
  ysyx_24100029_axi_sram_if.slave bus
);

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [7:0] LAT_INIT =
    8'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  lat_q, lat_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          beat_err;
  logic          last_beat;
  logic [31:0]   next_addr;
  logic          mem_we;

  // Addresses below BASE wrap to huge indices and fall out of range.
  assign word_idx  = (addr_q - BASE) >> 2;
  assign mem_idx   = word_idx[AW-1:0];
  assign beat_err  = (word_idx >= MEM_WORDS) || burst_q[1];
  assign last_beat = (beat_q == len_q);
  assign next_addr = (burst_q == 2'b01) ? addr_q + 32'd4 : addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    bus.awready = 1'b0;
    bus.arready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.bid     = '0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    bus.rid     = '0;

    unique case (state_q)
      S_IDLE: begin
        // Write wins a same-cycle tie; the read waits.
        bus.awready = 1'b1;
        bus.arready = !bus.awvalid;
        if (bus.awvalid) begin
          id_d    = bus.awid;
          addr_d  = bus.awaddr;
          len_d   = bus.awlen;
          burst_d = bus.awburst;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_WR_DATA;
        end else if (bus.arvalid) begin
          id_d    = bus.arid;
          addr_d  = bus.araddr;
          len_d   = bus.arlen;
          burst_d = bus.arburst;
          beat_d  = '0;
          lat_d   = LAT_INIT;
          state_d = (RD_LAT > 1) ? S_RD_WAIT : S_RD_DATA;
        end
      end

      S_RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RD_DATA;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end

      S_RD_DATA: begin
        bus.rvalid = 1'b1;
        bus.rid    = id_q;
        bus.rlast  = last_beat;
        bus.rresp  = beat_err ? 2'b10 : 2'b00;
        bus.rdata  = beat_err ? '0 : mem[mem_idx];
        if (bus.rready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end

      S_WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          mem_we = !beat_err;
          err_d  = err_q | beat_err | (bus.wlast != last_beat);
          if (bus.wlast || last_beat) begin
            beat_d  = '0;
            state_d = S_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = next_addr;
          end
        end
      end

      S_WR_RESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = id_q;
        bus.bresp  = err_q ? 2'b10 : 2'b00;
        if (bus.bready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
